// File: rtl/rr_mux_pipe_if.sv
// rr_mux_pipe_if: producer-side and consumer-side signals of the rr_mux_pipe.
// The slave modport is the mux view; the master modport is the surrounding
// environment (producers, consumer and select control).
interface rr_mux_pipe_if #(
   parameter int N = 8,
   parameter int W = 8
);
   localparam int SW = $clog2(N);

   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [SW-1:0]  sel;
   logic           mode;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic [SW-1:0]  out_ch;
   logic           sel_err;

   modport master (
      output in_data, in_valid, sel, mode, out_ready,
      input  in_ready, out_data, out_valid, out_ch, sel_err
   );

   modport slave (
      input  in_data, in_valid, sel, mode, out_ready,
      output in_ready, out_data, out_valid, out_ch, sel_err
   );
endinterface

// File: rtl/rr_mux_pipe.sv
// rr_mux_pipe: N-channel, W-bit registered multiplexer with valid/ready
// handshake, manual select or round-robin auto scan.
// Build macro RR_MUX_PIPE_STAGE_EN: adds a register stage after the first
// (pairwise 2:1) tree level plus a skid slot, giving latency 2 at full
// throughput. Undefined (default): single output register, latency 1.
module rr_mux_pipe #(
   parameter int N  = 8,
   parameter int W  = 8,
   parameter int SW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   rr_mux_pipe_if.slave bus
);
   genvar gi;

   // architectural state shared by both build variants
   logic [SW-1:0] rr_ptr_reg;
   logic          sel_err_reg;
   logic [W-1:0]  out_data_reg;
   logic          out_valid_reg;
   logic [SW-1:0] out_ch_reg;

   // request steering
   logic          out_free;
   logic          accept_ok;
   logic          sel_in_range;
   logic          man_hit;
   logic          auto_hit;
   logic [SW-1:0] auto_grant;
   logic [N-1:0]  upper_valid;
   logic          req_hit;
   logic [SW-1:0] req_ch;
   logic          accept;
   logic [SW-1:0] rr_ptr_next;
   logic          sel_err_next;
   logic [N-1:0]  in_ready_vec;
   logic [W-1:0]  chan_word [N];

   // Per-channel slices, the "at or above rr_ptr" valid mask used by the
   // round-robin scan, and the one-hot ready decode.
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         assign chan_word[gi]    = bus.in_data[gi*W +: W];
         assign upper_valid[gi]  = bus.in_valid[gi] && (SW'(gi) >= rr_ptr_reg);
         assign in_ready_vec[gi] = accept && (req_ch == SW'(gi));
      end
   endgenerate

   assign bus.in_ready  = in_ready_vec;
   assign bus.out_data  = out_data_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_ch    = out_ch_reg;
   assign bus.sel_err   = sel_err_reg;

   // Round-robin grant: lowest valid channel at or above rr_ptr, else wrap
   // around to the lowest valid channel overall.
   always_comb begin
      auto_hit   = 1'b0;
      auto_grant = '0;
      for (int c = 0; c < N; c++) begin
         if (!auto_hit && upper_valid[c]) begin
            auto_hit   = 1'b1;
            auto_grant = SW'(c);
         end
      end
      for (int c = 0; c < N; c++) begin
         if (!auto_hit && bus.in_valid[c]) begin
            auto_hit   = 1'b1;
            auto_grant = SW'(c);
         end
      end
   end

   // Manual select qualification; sel may exceed N-1 when N is not a power of two.
   always_comb begin
      sel_in_range = (int'(bus.sel) < N);
      man_hit      = 1'b0;
      for (int c = 0; c < N; c++) begin
         if ((bus.sel == SW'(c)) && bus.in_valid[c]) begin
            man_hit = 1'b1;
         end
      end
   end

   // Mode steering, accept decision, pointer advance and select error.
   always_comb begin
      req_hit      = bus.mode ? auto_hit : man_hit;
      req_ch       = bus.mode ? auto_grant : bus.sel;
      accept       = accept_ok && req_hit;
      sel_err_next = !bus.mode && accept_ok && !sel_in_range;
      rr_ptr_next  = rr_ptr_reg;
      if (bus.mode && accept) begin
         rr_ptr_next = (auto_grant == SW'(N - 1)) ? '0 : auto_grant + SW'(1);
      end
   end

   // Round-robin pointer and select-error pulse register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg  <= '0;
         sel_err_reg <= 1'b0;
      end else begin
         rr_ptr_reg  <= rr_ptr_next;
         sel_err_reg <= sel_err_next;
      end
   end

   assign out_free = !out_valid_reg || bus.out_ready;

`ifdef RR_MUX_PIPE_STAGE_EN
   localparam int P = (N + 1) / 2;

   logic [W-1:0]  pair_word   [P];
   logic [W-1:0]  s1_pair_reg [P];
   logic          s1_valid_reg;
   logic [SW-1:0] s1_ch_reg;
   logic [W-1:0]  s1_word;
   logic          skid_valid_reg;
   logic [W-1:0]  skid_data_reg;
   logic [SW-1:0] skid_ch_reg;
   logic          s1_to_out;
   logic          s1_to_skid;

   // First tree level: every pair is reduced by the select LSB; an odd last
   // channel passes straight through.
   generate
      for (gi = 0; gi < P; gi++) begin : g_pair
         if (2*gi + 1 < N) begin : g_two
            assign pair_word[gi] = req_ch[0] ? chan_word[2*gi + 1] : chan_word[2*gi];
         end else begin : g_one
            assign pair_word[gi] = chan_word[2*gi];
         end
      end
   endgenerate

   // Intake is gated only by the registered skid state, so in_ready does not
   // combinationally depend on out_ready in this variant.
   assign accept_ok  = rst_n && !skid_valid_reg;
   assign s1_to_out  = s1_valid_reg && !skid_valid_reg && out_free;
   assign s1_to_skid = s1_valid_reg && !skid_valid_reg && !out_free;

   // Second tree level: pick the registered pair using the upper select bits.
   always_comb begin
      s1_word = s1_pair_reg[0];
      for (int p = 1; p < P; p++) begin
         if ((s1_ch_reg >> 1) == SW'(p)) begin
            s1_word = s1_pair_reg[p];
         end
      end
   end

   // Stage-1 register: captures all pair results on an accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_ch_reg    <= '0;
         for (int p = 0; p < P; p++) begin
            s1_pair_reg[p] <= '0;
         end
      end else begin
         if (accept) begin
            s1_ch_reg <= req_ch;
            for (int p = 0; p < P; p++) begin
               s1_pair_reg[p] <= pair_word[p];
            end
         end
         if (accept) begin
            s1_valid_reg <= 1'b1;
         end else if (s1_to_out || s1_to_skid) begin
            s1_valid_reg <= 1'b0;
         end
      end
   end

   // Skid slot: parks the stage-1 word while the output is stalled so the
   // word accepted in the same cycle is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
         skid_ch_reg    <= '0;
      end else if (s1_to_skid) begin
         skid_valid_reg <= 1'b1;
         skid_data_reg  <= s1_word;
         skid_ch_reg    <= s1_ch_reg;
      end else if (skid_valid_reg && out_free) begin
         skid_valid_reg <= 1'b0;
      end
   end

   // Output register: the older skid word has priority over stage 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_ch_reg    <= '0;
      end else if (out_free) begin
         if (skid_valid_reg) begin
            out_data_reg  <= skid_data_reg;
            out_ch_reg    <= skid_ch_reg;
            out_valid_reg <= 1'b1;
         end else if (s1_valid_reg) begin
            out_data_reg  <= s1_word;
            out_ch_reg    <= s1_ch_reg;
            out_valid_reg <= 1'b1;
         end else begin
            out_valid_reg <= 1'b0;
         end
      end
   end
`else
   logic [W-1:0] sel_word;

   // A new word may enter only when the output register is empty or draining.
   assign accept_ok = rst_n && out_free;

   // Full N:1 data select for the granted channel.
   always_comb begin
      sel_word = chan_word[0];
      for (int c = 1; c < N; c++) begin
         if (req_ch == SW'(c)) begin
            sel_word = chan_word[c];
         end
      end
   end

   // Output register: load on accept, clear valid when free with no request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_ch_reg    <= '0;
      end else if (out_free) begin
         out_valid_reg <= accept;
         if (accept) begin
            out_data_reg <= sel_word;
            out_ch_reg   <= req_ch;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rr_mux_pipe.sv
// tb_rr_mux_pipe: directed self-checking bench for rr_mux_pipe.
// Two instances: N=8 (manual, stall, round-robin, reset) and N=6 (select error).
`timescale 1ns/1ps
module tb_rr_mux_pipe;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rr_mux_pipe_if #(.N(8), .W(8)) bus8 ();
   rr_mux_pipe_if #(.N(6), .W(8)) bus6 ();

   rr_mux_pipe #(.N(8), .W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   rr_mux_pipe #(.N(6), .W(8)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // advance one clock and sample 1 ns after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
      $display("t=%0t n8: v=%0b ch=%0d d=%02h rdy=%02h | n6: v=%0b ch=%0d d=%02h err=%0b",
               $time, bus8.out_valid, bus8.out_ch, bus8.out_data, bus8.in_ready,
               bus6.out_valid, bus6.out_ch, bus6.out_data, bus6.sel_err);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] exp_grant [3];
      int e;

      // ---------------- 1. reset with random inputs ----------------
      bus8.mode      = 1'b0;
      bus8.sel       = 3'($urandom_range(0, 7));
      bus8.in_valid  = 8'($urandom);
      bus8.out_ready = 1'($urandom);
      bus6.mode      = 1'b0;
      bus6.sel       = 3'($urandom_range(0, 7));
      bus6.in_valid  = 6'($urandom);
      bus6.out_ready = 1'($urandom);
      for (int c = 0; c < 8; c++) bus8.in_data[c*8 +: 8] = 8'($urandom);
      for (int c = 0; c < 6; c++) bus6.in_data[c*8 +: 8] = 8'($urandom);
      tick();
      tick();
      chk("rst_out_valid", bus8.out_valid, 0);
      chk("rst_out_data",  bus8.out_data,  0);
      chk("rst_out_ch",    bus8.out_ch,    0);
      chk("rst_in_ready",  bus8.in_ready,  0);
      chk("rst_sel_err",   bus8.sel_err,   0);
      chk("rst6_in_ready", bus6.in_ready,  0);
      chk("rst6_valid",    bus6.out_valid, 0);

      // quiet inputs, then release reset
      bus8.in_valid  = '0;
      bus8.sel       = '0;
      bus8.out_ready = 1'b1;
      bus6.in_valid  = '0;
      bus6.sel       = '0;
      bus6.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) bus8.in_data[c*8 +: 8] = 8'(8'h10 + c);
      for (int c = 0; c < 6; c++) bus6.in_data[c*8 +: 8] = 8'(8'h20 + c);
      rst_n = 1'b1;
      tick();
      chk("idle_valid", bus8.out_valid, 0);

`ifdef RR_MUX_PIPE_STAGE_EN
      // ---------------- 2 (staged). manual sel=5, latency 2 ----------------
      bus8.in_valid = 8'hFF;
      bus8.sel      = 3'd5;
      #1;
      chk("st_in_ready", bus8.in_ready, 8'b0010_0000);
      tick();
      bus8.in_valid = 8'h00;
      chk("st_lat1_valid", bus8.out_valid, 0);
      tick();
      chk("st_lat2_valid", bus8.out_valid, 1);
      chk("st_lat2_data",  bus8.out_data,  8'h15);
      chk("st_lat2_ch",    bus8.out_ch,    5);
      tick();
      chk("st_drain_valid", bus8.out_valid, 0);

      // ---------------- 6 (staged). N=6 sel=7 ----------------
      bus6.in_valid = 6'h3F;
      bus6.sel      = 3'd7;
      #1;
      chk("st6_in_ready", bus6.in_ready, 0);
      tick();
      chk("st6_sel_err", bus6.sel_err, 1);
      bus6.sel = 3'd1;
      tick();
      chk("st6_sel_err_end", bus6.sel_err, 0);
      chk("st6_valid_none",  bus6.out_valid, 0);
`else
      // ---------------- 2. manual select ----------------
      bus8.in_valid = 8'hFF;
      bus8.sel      = 3'd5;
      #1;
      chk("man_in_ready", bus8.in_ready, 8'b0010_0000);
      tick();
      chk("man_data",  bus8.out_data,  8'h15);
      chk("man_ch",    bus8.out_ch,    5);
      chk("man_valid", bus8.out_valid, 1);

      // ---------------- 3. stall 3 cycles while sel changes ----------------
      bus8.out_ready = 1'b0;
      bus8.sel = 3'd2;
      #1;
      chk("stall_in_ready_a", bus8.in_ready, 0);
      tick();
      chk("stall_data_a", bus8.out_data, 8'h15);
      bus8.sel = 3'd3;
      #1;
      chk("stall_in_ready_b", bus8.in_ready, 0);
      tick();
      chk("stall_ch_b", bus8.out_ch, 5);
      bus8.sel = 3'd6;
      #1;
      chk("stall_in_ready_c", bus8.in_ready, 0);
      tick();
      chk("stall_data_c",  bus8.out_data,  8'h15);
      chk("stall_valid_c", bus8.out_valid, 1);
      bus8.out_ready = 1'b1;
      #1;
      chk("unstall_in_ready", bus8.in_ready, 8'b0100_0000);
      tick();
      chk("unstall_data", bus8.out_data, 8'h16);
      chk("unstall_ch",   bus8.out_ch,   6);

      bus8.in_valid = 8'h00;
      #1;
      chk("novalid_in_ready", bus8.in_ready, 0);
      tick();
      chk("novalid_out_valid", bus8.out_valid, 0);

      // ---------------- 4. auto, all valid, sequence 0..7,0 ----------------
      bus8.mode     = 1'b1;
      bus8.in_valid = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         e = k % 8;
         #1;
         chk("rr_in_ready", bus8.in_ready, 32'(1) << e);
         tick();
         chk("rr_ch",   bus8.out_ch,   e);
         chk("rr_data", bus8.out_data, 8'h10 + e);
      end

      // ---------------- 5. auto sparse valid, pointer wrap ----------------
      // pointer is 1 here; a lone grant on channel 2 moves it to 3
      bus8.in_valid = 8'b0000_0100;
      #1;
      chk("sparse_pre_in_ready", bus8.in_ready, 8'b0000_0100);
      tick();
      chk("sparse_pre_ch", bus8.out_ch, 2);
      bus8.in_valid = 8'b1000_0100;
      exp_grant[0] = 3'd7;
      exp_grant[1] = 3'd2;
      exp_grant[2] = 3'd7;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("sparse_in_ready", bus8.in_ready, 32'(1) << exp_grant[k]);
         tick();
         chk("sparse_ch", bus8.out_ch, 32'(exp_grant[k]));
      end
      // grant 7 wrapped the pointer to 0
      bus8.in_valid = 8'hFF;
      #1;
      chk("wrap_in_ready", bus8.in_ready, 8'b0000_0001);
      tick();
      chk("wrap_ch", bus8.out_ch, 0);

      // manual interlude keeps the pointer (now 1)
      bus8.mode = 1'b0;
      bus8.sel  = 3'd4;
      tick();
      chk("modesw_man_ch", bus8.out_ch, 4);
      bus8.mode = 1'b1;
      #1;
      chk("modesw_in_ready", bus8.in_ready, 8'b0000_0010);
      tick();
      chk("modesw_auto_ch", bus8.out_ch, 1);

      // no valid in auto: output empties and the pointer (2) holds
      bus8.in_valid = 8'h00;
      tick();
      chk("auto_idle_valid", bus8.out_valid, 0);
      bus8.in_valid = 8'h0F;
      #1;
      chk("ptr_hold_in_ready", bus8.in_ready, 8'b0000_0100);
      tick();
      chk("ptr_hold_ch", bus8.out_ch, 2);

      // ---------------- reset mid-transfer ----------------
      bus8.mode     = 1'b0;
      bus8.sel      = 3'd3;
      bus8.in_valid = 8'hFF;
      tick();
      chk("pre_rst_data", bus8.out_data, 8'h13);
      bus8.out_ready = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid",    bus8.out_valid, 0);
      chk("midrst_data",     bus8.out_data,  0);
      chk("midrst_in_ready", bus8.in_ready,  0);
      bus8.out_ready = 1'b1;
      tick();
      chk("midrst_in_ready_hold", bus8.in_ready, 0);
      rst_n = 1'b1;
      tick();
      chk("postrst_ch",    bus8.out_ch,    3);
      chk("postrst_valid", bus8.out_valid, 1);
      bus8.mode = 1'b1;
      #1;
      chk("postrst_ptr_in_ready", bus8.in_ready, 8'b0000_0001);
      bus8.in_valid = 8'h00;
      tick();

      // ---------------- 6. N=6 select error ----------------
      bus6.mode     = 1'b0;
      bus6.in_valid = 6'h3F;
      bus6.sel      = 3'd7;
      #1;
      chk("err_in_ready", bus6.in_ready, 0);
      tick();
      chk("err_pulse",  bus6.sel_err,   1);
      chk("err_nodata", bus6.out_valid, 0);
      bus6.sel = 3'd5;
      #1;
      chk("err_ok_in_ready", bus6.in_ready, 6'b10_0000);
      tick();
      chk("err_clear", bus6.sel_err,  0);
      chk("n6_data",   bus6.out_data, 8'h25);
      chk("n6_ch",     bus6.out_ch,   5);
      // stalled: no error even with an out-of-range select
      bus6.out_ready = 1'b0;
      bus6.sel       = 3'd7;
      tick();
      chk("err_stall_none", bus6.sel_err,  0);
      chk("n6_stall_data",  bus6.out_data, 8'h25);
      // auto mode ignores sel entirely
      bus6.out_ready = 1'b1;
      bus6.mode      = 1'b1;
      tick();
      chk("err_auto_none", bus6.sel_err, 0);
      chk("n6_auto_ch",    bus6.out_ch,  0);
      bus6.mode = 1'b0;
      bus6.sel  = 3'd6;
      tick();
      chk("err_sel6", bus6.sel_err, 1);
      bus6.sel = 3'd1;
      tick();
      chk("err_sel6_end", bus6.sel_err, 0);
      chk("n6_sel1_ch",   bus6.out_ch,  1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
